// File: rtl/uart_tx_arb_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding and defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_tx_arb_pkg;

   localparam int DEF_NREQ     = 4;
   localparam int DEF_BUSY_TMO = 3;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first valid requester at or after ptr, wrapping.
// Latency: zero cycles (pure combinational).
// Backpressure: none; winner is zero when no requester is valid.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int PW   = 2
) (
   input  logic [NREQ-1:0] valid,
   input  logic [PW-1:0]   ptr,
   output logic [NREQ-1:0] winner
);

   logic found;

   // First pass covers ptr..NREQ-1, second pass wraps to 0..ptr-1.
   always_comb begin
      winner = '0;
      found  = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (!found && valid[i] && (i >= int'(ptr))) begin
            winner[i] = 1'b1;
            found     = 1'b1;
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!found && valid[i]) begin
            winner[i] = 1'b1;
            found     = 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding one UART transmitter from NREQ byte requesters (packet lock with UART_TX_ARB_LOCK_EN).
// Latency: req_ready pulses in accept cycle N, txValid/txData presented in N+1.
// Backpressure: no accept while txBusy=1 or a byte is in flight; missing txBusy after BUSY_TMO cycles sets sticky tmo_err.
module uart_tx_arbiter
   import uart_tx_arb_pkg::*;
#(
   parameter int NREQ     = DEF_NREQ,
   parameter int BUSY_TMO = DEF_BUSY_TMO
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [8*NREQ-1:0] req_data,
   input  logic [NREQ-1:0]   req_last,
   output logic [NREQ-1:0]   req_ready,
   output logic [7:0]        txData,
   output logic              txValid,
   input  logic              txBusy,
   output logic [NREQ-1:0]   grant,
   output logic              tmo_err
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(BUSY_TMO + 1);

   arb_state_t      state_q, state_d;
   logic [PW-1:0]   ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [7:0]      tx_data_q;
   logic            tx_valid_q;
   logic [NREQ-1:0] grant_q;
   logic            tmo_q;
   logic [NREQ-1:0] elig;
   logic [NREQ-1:0] win;
   logic [PW-1:0]   win_idx;
   logic [PW-1:0]   ptr_nxt;
   logic [7:0]      win_byte;
   logic            win_last;
   logic            accept;
   logic            tmo_hit;
   logic            lock_held;

`ifdef UART_TX_ARB_LOCK_EN
   logic lock_q;

   // While a packet is open only the owning requester is eligible.
   assign elig      = lock_q ? (req_valid & grant_q) : req_valid;
   assign lock_held = lock_q;
`else
   logic unused_last;

   assign elig        = req_valid;
   assign lock_held   = 1'b0;
   assign unused_last = ^{req_last, win_last};
`endif

   rr_pick #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_rr_pick (
      .valid  (elig),
      .ptr    (ptr_q),
      .winner (win)
   );

   // Encode the one-hot winner into an index and select its byte and last flag.
   always_comb begin
      win_idx  = '0;
      win_byte = 8'h00;
      win_last = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         if (win[k]) begin
            win_idx  = PW'(k);
            win_byte = req_data[8*k +: 8];
            win_last = req_last[k];
         end
      end
   end

   assign ptr_nxt = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);

   // Reset gates the accept so no requester is ever handshaken during reset.
   assign accept    = reset && (state_q == IDLE) && !txBusy && (|win);
   assign req_ready = accept ? win : '0;
   assign txData    = tx_data_q;
   assign txValid   = tx_valid_q;
   assign grant     = grant_q;
   assign tmo_err   = tmo_q;

   // State register.
   always_ff @(posedge clock) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic; tmo_hit flags the last unanswered WAIT_BUSY cycle.
   always_comb begin
      state_d = state_q;
      tmo_hit = 1'b0;
      case (state_q)
         IDLE:      if (accept) state_d = ISSUE;
         ISSUE:     state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (txBusy) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == CW'(BUSY_TMO - 1)) begin
               state_d = IDLE;
               tmo_hit = 1'b1;
            end
         end
         WAIT_DONE: if (!txBusy) state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // Datapath: byte latch, strobe, round-robin pointer, grant, timeout counter and sticky error.
   always_ff @(posedge clock) begin
      if (!reset) begin
         ptr_q      <= '0;
         cnt_q      <= '0;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         grant_q    <= '0;
         tmo_q      <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
         lock_q     <= 1'b0;
`endif
      end else begin
         tx_valid_q <= accept;
         if (accept) begin
            tx_data_q <= win_byte;
            grant_q   <= win;
            ptr_q     <= ptr_nxt;
`ifdef UART_TX_ARB_LOCK_EN
            lock_q    <= !win_last;
`endif
         end else if ((state_q != IDLE) && (state_d == IDLE) && !lock_held) begin
            grant_q <= '0;
         end
         if (state_q == WAIT_BUSY) cnt_q <= cnt_q + CW'(1);
         else                      cnt_q <= '0;
         if (tmo_hit) tmo_q <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (NREQ=4, BUSY_TMO=3).
// Inputs are driven 2 time units after the rising edge, outputs sampled 1 unit later.
// A small UART model can raise txBusy one cycle after txValid for a set number of cycles.
module tb_uart_tx_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  req_last = '1;
   logic [3:0]  req_ready;
   logic [7:0]  txData;
   logic        txValid;
   logic        txBusy = 1'b0;
   logic [3:0]  grant;
   logic        tmo_err;

   int total = 0;
   int bad   = 0;

   logic       auto_uart = 1'b0;
   int         busy_len  = 10;
   int         bcnt      = 0;
   logic       saw_valid = 1'b0;
   logic [7:0] mon_q[$];

   uart_tx_arbiter #(.NREQ(4), .BUSY_TMO(3)) dut (
      .clock     (clock),
      .reset     (reset),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .txData    (txData),
      .txValid   (txValid),
      .txBusy    (txBusy),
      .grant     (grant),
      .tmo_err   (tmo_err)
   );

   always #5 clock = ~clock;

   // Record every byte handed to the UART.
   always @(negedge clock) begin
      saw_valid = (txValid === 1'b1);
      if (txValid === 1'b1) mon_q.push_back(txData);
   end

   // UART model: busy rises the cycle after txValid and stays up busy_len cycles.
   always @(posedge clock) begin
      #1;
      if (auto_uart) begin
         if (bcnt > 0) begin
            bcnt = bcnt - 1;
            if (bcnt == 0) txBusy = 1'b0;
         end else if (saw_valid) begin
            txBusy = 1'b1;
            bcnt   = busy_len;
         end
      end
   end

   task automatic tick();
      @(posedge clock);
      #2;
   endtask

   task automatic reset_dut();
      req_valid = '0;
      req_last  = '1;
      auto_uart = 1'b0;
      bcnt      = 0;
      txBusy    = 1'b0;
      reset     = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = 4'b1111;
      tick();
      tick();
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      total++; if (txValid !== 1'b0) begin bad++; $display("FAIL reset_txvalid got=%b want=0", txValid); end
      total++; if (txData !== 8'h00) begin bad++; $display("FAIL reset_txdata got=%h want=00", txData); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL reset_grant got=%b want=0000", grant); end
      total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL reset_tmo got=%b want=0", tmo_err); end
      req_valid = '0;
      reset     = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bit done = 0;
      busy_len  = 10;
      auto_uart = 1'b1;
      tick();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0041;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b want=0001", req_ready); end
      tick();
      req_valid = '0;
      #1;
      total++; if (txValid !== 1'b1) begin bad++; $display("FAIL single_txvalid got=%b want=1", txValid); end
      total++; if (txData !== 8'h41) begin bad++; $display("FAIL single_txdata got=%h want=41", txData); end
      total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant got=%b want=0001", grant); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL single_ready_drop got=%b want=0000", req_ready); end
      tick();
      #1;
      total++; if (txValid !== 1'b0) begin bad++; $display("FAIL single_strobe_len got=%b want=0", txValid); end
      for (int c = 0; c < 30 && !done; c++) begin
         total++; if (grant !== 4'b0001) begin bad++; $display("FAIL single_grant_hold got=%b want=0001", grant); end
         if (txBusy === 1'b0) done = 1;
         else begin tick(); #1; end
      end
      total++; if (!done) begin bad++; $display("FAIL single_busy_fall got=stuck want=fall"); end
      tick();
      #1;
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL single_grant_clear got=%b want=0000", grant); end
      auto_uart = 1'b0;
   endtask

   task automatic test_fairness();
      logic [7:0] exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
      reset_dut();
      busy_len  = 2;
      auto_uart = 1'b1;
      mon_q.delete();
      req_data  = 32'h1312_1110;
      req_valid = 4'b1111;
      for (int c = 0; c < 200 && mon_q.size() < 5; c++) tick();
      for (int i = 0; i < 5; i++) begin
         total++;
         if (mon_q.size() <= i || mon_q[i] !== exp[i]) begin
            bad++;
            $display("FAIL fair_order[%0d] got=%h want=%h (bytes seen=%0d)", i,
                     (mon_q.size() > i) ? mon_q[i] : 8'hxx, exp[i], mon_q.size());
         end
      end
      req_valid = '0;
   endtask

   task automatic test_timeout();
      reset_dut();
      tick();
      req_valid = 4'b0001;
      req_data  = 32'h0000_0055;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL tmo_ready got=%b want=0001", req_ready); end
      tick();
      req_valid = '0;
      #1;
      total++; if (txValid !== 1'b1 || txData !== 8'h55) begin bad++; $display("FAIL tmo_issue got=%b/%h want=1/55", txValid, txData); end
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_early[%0d] got=%b want=0", k, tmo_err); end
      end
      tick();
      req_valid = 4'b0010;
      req_data  = 32'h0000_6600;
      #1;
      total++; if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b want=1", tmo_err); end
      total++; if (req_ready !== 4'b0010) begin bad++; $display("FAIL tmo_next_ready got=%b want=0010", req_ready); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL tmo_grant got=%b want=0000", grant); end
      tick();
      req_valid = '0;
      #1;
      total++; if (txValid !== 1'b1 || txData !== 8'h66) begin bad++; $display("FAIL tmo_next_issue got=%b/%h want=1/66", txValid, txData); end
      repeat (4) tick();
      #1;
      total++; if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky got=%b want=1", tmo_err); end
   endtask

   task automatic test_lock();
      int r1 = 0;
`ifdef UART_TX_ARB_LOCK_EN
      logic [7:0] exp [5] = '{8'hA1, 8'hA2, 8'hA3, 8'hB0, 8'hB0};
`else
      logic [7:0] exp [5] = '{8'hA1, 8'hB0, 8'hA2, 8'hB0, 8'hA3};
`endif
      reset_dut();
      busy_len  = 2;
      auto_uart = 1'b1;
      mon_q.delete();
      for (int c = 0; c < 300 && mon_q.size() < 5; c++) begin
         tick();
         req_valid[2]      = 1'b1;
         req_data[23:16]   = 8'hB0;
         req_last[2]       = 1'b1;
         req_valid[1]      = (r1 < 3);
         req_data[15:8]    = 8'(8'hA1 + r1);
         req_last[1]       = (r1 == 2);
         #1;
         if (req_ready[1] === 1'b1) r1++;
      end
      for (int i = 0; i < 5; i++) begin
         total++;
         if (mon_q.size() <= i || mon_q[i] !== exp[i]) begin
            bad++;
            $display("FAIL lock_order[%0d] got=%h want=%h (bytes seen=%0d)", i,
                     (mon_q.size() > i) ? mon_q[i] : 8'hxx, exp[i], mon_q.size());
         end
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      reset_dut();
      tick();
      req_valid = 4'b0100;
      req_data  = 32'h0077_0000;
      #1;
      total++; if (req_ready !== 4'b0100) begin bad++; $display("FAIL mid_ready got=%b want=0100", req_ready); end
      tick();
      req_valid = '0;
      txBusy    = 1'b1;
      #1;
      total++; if (txValid !== 1'b1 || txData !== 8'h77) begin bad++; $display("FAIL mid_issue got=%b/%h want=1/77", txValid, txData); end
      tick();
      tick();
      req_valid = 4'b1111;
      req_data  = 32'h8382_8180;
      reset     = 1'b0;
      #1;
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_in_reset_ready got=%b want=0000", req_ready); end
      tick();
      reset = 1'b1;
      #1;
      total++; if (txValid !== 1'b0) begin bad++; $display("FAIL mid_txvalid got=%b want=0", txValid); end
      total++; if (grant !== 4'b0000) begin bad++; $display("FAIL mid_grant got=%b want=0000", grant); end
      total++; if (txData !== 8'h00) begin bad++; $display("FAIL mid_txdata got=%h want=00", txData); end
      total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL mid_tmo got=%b want=0", tmo_err); end
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL mid_busy_ready got=%b want=0000", req_ready); end
      for (int k = 0; k < 3; k++) begin
         tick();
         #1;
         total++; if (req_ready !== 4'b0000 || txValid !== 1'b0) begin bad++; $display("FAIL mid_hold[%0d] got=%b/%b want=0000/0", k, req_ready, txValid); end
      end
      tick();
      txBusy = 1'b0;
      #1;
      total++; if (req_ready !== 4'b0001) begin bad++; $display("FAIL mid_first_ready got=%b want=0001", req_ready); end
      tick();
      req_valid = '0;
      #1;
      total++; if (txValid !== 1'b1 || txData !== 8'h80) begin bad++; $display("FAIL mid_first_issue got=%b/%h want=1/80", txValid, txData); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_fairness();
      test_timeout();
      test_lock();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

endmodule
